// File: rtl/pe_sched_pkg.sv
// Shared types and defaults for the PE job scheduler.
// Pure declarations: no logic, no latency, no flow control.
package pe_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pe_slot_state_t;

    localparam int PE_SCHED_NUM_PE   = 4;
    localparam int PE_SCHED_JOB_ID_W = 4;

    // Round-robin successor of a slot index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, as one-hot and index.
// Purely combinational; the caller owns the pointer and advances it on use.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pe_scheduler.sv
// Dispatches tagged jobs round-robin to NUM_PE engines and returns completions; watchdog under PE_SCHED_TIMEOUT_EN.
// Latency: start pulse 1 cycle after job handshake; completion presented 1 cycle after a slot reaches DONE.
// Backpressure: o_job_ready drops when no slot is IDLE; completion fields hold while i_done_ready is low.
module pe_scheduler
    import pe_sched_pkg::*;
#(
    parameter int NUM_PE      = PE_SCHED_NUM_PE,
    parameter int JOB_ID_W    = PE_SCHED_JOB_ID_W,
    parameter int TIMEOUT_CYC = 256,
    localparam int IDX_W      = $clog2(NUM_PE)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_job_valid,
    input  logic [JOB_ID_W-1:0] i_job_id,
    output logic                o_job_ready,
    output logic [NUM_PE-1:0]   o_pe_start,
    output logic [IDX_W-1:0]    o_load_sel,
    input  logic [NUM_PE-1:0]   i_pe_finish,
    output logic [NUM_PE-1:0]   o_busy,
    output logic                o_done_valid,
    output logic [IDX_W-1:0]    o_done_pe,
    output logic [JOB_ID_W-1:0] o_done_id,
    output logic                o_done_timeout,
    input  logic                i_done_ready
);

    if (NUM_PE < 2 || NUM_PE > 16 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("pe_scheduler: NUM_PE must be 2..16 and TIMEOUT_CYC at least 2");
    end

    pe_slot_state_t      state [NUM_PE];
    logic [JOB_ID_W-1:0] tag   [NUM_PE];
    logic [IDX_W-1:0]    disp_ptr, comp_ptr, disp_idx, comp_idx;
    logic [NUM_PE-1:0]   idle_vec, done_vec, fin_ok, timeout_hit;
    logic [NUM_PE-1:0]   disp_gnt, comp_gnt, comp_sel;
    logic                job_fire, comp_fire, comp_load;

    // Finish is ignored during the start-pulse cycle: the PE has not latched its job yet.
    always_comb begin
        idle_vec = '0;
        done_vec = '0;
        fin_ok   = '0;
        o_busy   = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            idle_vec[i] = (state[i] == IDLE);
            done_vec[i] = (state[i] == DONE);
            o_busy[i]   = (state[i] != IDLE);
            fin_ok[i]   = (state[i] == RUN) && i_pe_finish[i] && !o_pe_start[i];
        end
    end

    assign o_job_ready = |idle_vec;
    assign job_fire    = i_job_valid && o_job_ready;
    assign comp_fire   = o_done_valid && i_done_ready;
    assign comp_load   = !o_done_valid && (|done_vec);

    rr_arbiter #(.N(NUM_PE), .IDX_W(IDX_W)) u_disp_arb (
        .req       (idle_vec),
        .ptr       (disp_ptr),
        .grant     (disp_gnt),
        .grant_idx (disp_idx)
    );

    rr_arbiter #(.N(NUM_PE), .IDX_W(IDX_W)) u_comp_arb (
        .req       (done_vec),
        .ptr       (comp_ptr),
        .grant     (comp_gnt),
        .grant_idx (comp_idx)
    );

    // The completion register is reloaded only when empty, so a slot that goes DONE
    // while a completion is stalled cannot disturb the presented fields.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_PE; i++) begin
                state[i] <= IDLE;
                tag[i]   <= '0;
            end
            disp_ptr     <= '0;
            comp_ptr     <= '0;
            o_pe_start   <= '0;
            o_load_sel   <= '0;
            o_done_valid <= 1'b0;
            o_done_pe    <= '0;
            o_done_id    <= '0;
            comp_sel     <= '0;
        end else begin
            o_pe_start <= job_fire ? disp_gnt : '0;
            if (job_fire) begin
                o_load_sel <= disp_idx;
                disp_ptr   <= IDX_W'(rr_next(int'(disp_idx), NUM_PE));
            end
            if (comp_fire) begin
                o_done_valid <= 1'b0;
            end else if (comp_load) begin
                o_done_valid <= 1'b1;
                o_done_pe    <= comp_idx;
                o_done_id    <= tag[comp_idx];
                comp_sel     <= comp_gnt;
                comp_ptr     <= IDX_W'(rr_next(int'(comp_idx), NUM_PE));
            end
            for (int i = 0; i < NUM_PE; i++) begin
                case (state[i])
                    IDLE: if (job_fire && disp_gnt[i]) begin
                        state[i] <= RUN;
                        tag[i]   <= i_job_id;
                    end
                    RUN:  if (fin_ok[i] || timeout_hit[i]) state[i] <= DONE;
                    DONE: if (comp_fire && comp_sel[i]) state[i] <= IDLE;
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

`ifdef PE_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]  run_cnt [NUM_PE];
    logic [NUM_PE-1:0] to_flag;

    // A finish in the same cycle as the limit wins, so the job is not flagged.
    always_comb begin
        timeout_hit = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            timeout_hit[i] = (state[i] == RUN) && !fin_ok[i] &&
                             (run_cnt[i] == CNT_W'(TIMEOUT_CYC - 1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_PE; i++) run_cnt[i] <= '0;
            to_flag        <= '0;
            o_done_timeout <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (state[i] != RUN) begin
                    run_cnt[i] <= '0;
                    if (state[i] == IDLE) to_flag[i] <= 1'b0;
                end else begin
                    run_cnt[i] <= run_cnt[i] + 1'b1;
                    if (timeout_hit[i]) to_flag[i] <= 1'b1;
                end
            end
            if (comp_fire)      o_done_timeout <= 1'b0;
            else if (comp_load) o_done_timeout <= to_flag[comp_idx];
        end
    end
`else
    assign timeout_hit    = '0;
    assign o_done_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pe_scheduler.sv
// Bench for pe_scheduler: directed scenarios, then randomized traffic against a slot-level reference model.
module tb_pe_scheduler;

    localparam int N  = 4;
    localparam int IW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          job_valid = 1'b0;
    logic [IW-1:0] job_id = '0;
    logic          job_ready;
    logic [N-1:0]  pe_start;
    logic [1:0]    load_sel;
    logic [N-1:0]  pe_finish = '0;
    logic [N-1:0]  busy;
    logic          done_valid;
    logic [1:0]    done_pe;
    logic [IW-1:0] done_id;
    logic          done_timeout;
    logic          done_ready = 1'b0;

    pe_scheduler #(.NUM_PE(N), .JOB_ID_W(IW), .TIMEOUT_CYC(TO)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_job_valid    (job_valid),
        .i_job_id       (job_id),
        .o_job_ready    (job_ready),
        .o_pe_start     (pe_start),
        .o_load_sel     (load_sel),
        .i_pe_finish    (pe_finish),
        .o_busy         (busy),
        .o_done_valid   (done_valid),
        .o_done_pe      (done_pe),
        .o_done_id      (done_id),
        .o_done_timeout (done_timeout),
        .i_done_ready   (done_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-slot state (0 idle, 1 run, 2 done), tag and dispatch cycle.
    typedef struct { int pe; int due; } start_t;
    start_t  sq[$];
    int      m_st[N];
    int      m_tag[N];
    int      m_dcyc[N];
    int      m_ptr;
    bit      exp_pending[N];
    int      exp_id[N];
    bit      exp_to[N];
    bit      mon_en = 1'b0;
    logic    prev_v = 1'b0, prev_rdy = 1'b0;
    logic [7:0] prev_bundle = '0;

    task automatic monitor_cycle();
        start_t s;
        if (pe_start != '0) begin
            if (sq.size() == 0) begin
                chk("start_unexpected", pe_start, 0);
            end else begin
                s = sq.pop_front();
                chk("start_onehot", pe_start, 1 << s.pe);
                chk("start_load_sel", load_sel, s.pe);
                chk("start_cycle", cyc, s.due);
            end
        end else if (sq.size() > 0 && sq[0].due <= cyc) begin
            s = sq.pop_front();
            chk("start_missing", pe_start, 1 << s.pe);
        end
        if (prev_v && !prev_rdy)
            chk("done_hold", {done_valid, done_pe, done_id, done_timeout}, prev_bundle);
        if (done_valid && done_ready) begin
            chk("done_expected", exp_pending[done_pe], 1);
            if (exp_pending[done_pe]) begin
                chk("done_id", done_id, exp_id[done_pe]);
                chk("done_timeout_flag", done_timeout, exp_to[done_pe]);
                exp_pending[done_pe] = 1'b0;
            end
        end
        prev_v      = done_valid;
        prev_rdy    = done_ready;
        prev_bundle = {done_valid, done_pe, done_id, done_timeout};
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_en) monitor_cycle();
    end

    task automatic step(input bit jv, input logic [IW-1:0] id, input logic [N-1:0] fin, input bit dr);
        logic [N-1:0] mbusy;
        int any_idle, p, free_pe;
        tick();
        mbusy = '0;
        any_idle = 0;
        for (int q = 0; q < N; q++) begin
            if (m_st[q] != 0) mbusy[q] = 1'b1;
            else any_idle = 1;
        end
        chk("model_ready", job_ready, any_idle);
        chk("model_busy", busy, mbusy);
        job_valid  = jv;
        job_id     = id;
        pe_finish  = fin;
        done_ready = dr;
        free_pe = (done_valid && dr) ? int'(done_pe) : -1;
        for (int q = 0; q < N; q++) begin
            if (m_st[q] == 1) begin
                if (fin[q] && cyc > m_dcyc[q] + 1) begin
                    m_st[q] = 2; exp_pending[q] = 1'b1; exp_id[q] = m_tag[q]; exp_to[q] = 1'b0;
                end
`ifdef PE_SCHED_TIMEOUT_EN
                else if (cyc == m_dcyc[q] + TO) begin
                    m_st[q] = 2; exp_pending[q] = 1'b1; exp_id[q] = m_tag[q]; exp_to[q] = 1'b1;
                end
`endif
            end
        end
        if (jv && any_idle != 0) begin
            p = m_ptr;
            while (m_st[p] != 0) p = (p + 1) % N;
            m_st[p] = 1; m_tag[p] = int'(id); m_dcyc[p] = cyc;
            m_ptr = (p + 1) % N;
            sq.push_back('{pe: p, due: cyc + 1});
        end
        if (free_pe >= 0) m_st[free_pe] = 0;
    endtask

    task automatic wait_done(input int pe, input int id);
        int n = 0;
        while (!done_valid && n < 40) begin tick(); n++; end
        chk("done_seen", done_valid, 1);
        if (done_valid) begin
            chk("done_pe", done_pe, pe);
            chk("done_id", done_id, id);
            chk("done_to", done_timeout, 0);
        end
        tick();
    endtask

    initial begin
        int n;
        bit seen;
        logic [N-1:0] fin;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_start", pe_start, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_timeout", done_timeout, 0);
        chk("rst_job_ready", job_ready, 1);
        rst_n = 1'b1;
        tick();

        // Four back-to-back jobs fill PE0..PE3; finish on PE3 during its pulse is ignored
        job_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            job_id = IW'(k);
            tick();
            chk("start_seq", pe_start, 1 << (k - 1));
            chk("load_sel_seq", load_sel, k - 1);
            if (k == 4) pe_finish = 4'b1000;
        end
        chk("ready_full", job_ready, 0);
        job_id = 4'd5;
        tick();
        pe_finish = '0;
        job_valid = 1'b0;
        chk("no_start_full", pe_start, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pulse_finish_ignored", done_valid, 0);
        end
        chk("busy_full", busy, 4'b1111);

        // PE2 then PE0 finish
        done_ready = 1'b1;
        pe_finish = 4'b0100;
        tick();
        pe_finish = 4'b0001;
        tick();
        pe_finish = '0;
        wait_done(2, 3);
        wait_done(0, 1);
        chk("busy_after_two", busy, 4'b1010);
        job_valid = 1'b1;
        job_id = 4'd9;
        tick();
        job_valid = 1'b0;
        chk("job9_pe0", pe_start, 4'b0001);

        // Stalled completion on PE1 holds its fields
        done_ready = 1'b0;
        pe_finish = 4'b0010;
        tick();
        pe_finish = '0;
        n = 0;
        while (!done_valid && n < 40) begin tick(); n++; end
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", done_valid, 1);
            chk("stall_pe", done_pe, 1);
            chk("stall_id", done_id, 2);
            if (k < 4) tick();
        end
        done_ready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("single_completion", done_valid, 0);
            tick();
        end
        chk("busy_after_pe1", busy, 4'b1001);

        // Finish on idle PEs changes nothing
        pe_finish = 4'b0110;
        tick();
        tick();
        pe_finish = '0;
        for (int k = 0; k < 4; k++) begin
            chk("idle_finish_ignored", done_valid, 0);
            tick();
        end
        chk("busy_idle_finish", busy, 4'b1001);

        // Reset with three PEs running
        job_valid = 1'b1;
        job_id = 4'd7;
        tick();
        job_valid = 1'b0;
        chk("job7_pe1", pe_start, 4'b0010);
        chk("busy_three", busy, 4'b1011);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_start", pe_start, 0);
        chk("async_rst_valid", done_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        job_valid = 1'b1;
        job_id = 4'hA;
        tick();
        job_valid = 1'b0;
        chk("post_rst_pe0", pe_start, 4'b0001);

`ifdef PE_SCHED_TIMEOUT_EN
        // Slot goes DONE after TO cycles in RUN; the completion register presents it one cycle later.
        n = 0;
        while (!done_valid && n < 60) begin tick(); n++; end
        chk("timeout_latency", n, TO + 1);
        chk("timeout_flag", done_timeout, 1);
        chk("timeout_pe", done_pe, 0);
        chk("timeout_id", done_id, 4'hA);
        tick();
`else
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (done_valid) seen = 1'b1;
        end
        chk("no_timeout_completion", seen, 0);
        chk("no_timeout_busy", busy, 4'b0001);
`endif

        // Randomized traffic against the model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int q = 0; q < N; q++) begin
            m_st[q] = 0; m_tag[q] = 0; m_dcyc[q] = 0; exp_pending[q] = 1'b0;
        end
        m_ptr = 0;
        mon_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < N; b++) fin[b] = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 2) != 0, IW'($urandom), fin, $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 60; k++) step(1'b0, '0, '1, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        n = 0;
        for (int q = 0; q < N; q++) if (exp_pending[q]) n++;
        chk("drain_pending", n, 0);
        chk("drain_starts", sq.size(), 0);
        chk("drain_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
